// File: rtl/arb_burst_sequencer.sv
// -----------------------------------------------------------------------------
// arb_burst_sequencer
//
// Sits behind the round-robin grant logic. It samples the arbiter's winner
// while idle and locks that requester for a burst of len+1 beats. It muxes the
// owner's beats onto a single valid/ready output. It also owns the registered
// priority mask fed back to the arbiter. That mask advances only when a burst
// completes, not on every grant cycle.
//
// Parameters
//   WIDTH   number of requesters (power of two, >= 2)
//   DATA_W  beat data width
//   LEN_W   burst-length field width (burst = len + 1 beats)
//
// Ports
//   clk                  clock, all state on the rising edge
//   reset                asynchronous, active-high reset
//   req_vector           per-requester beat valid
//   req_data             flat per-requester beat data, slice i at [i*DATA_W +: DATA_W]
//   req_len              flat per-requester burst length minus one
//   grant_idx            arbiter winner index
//   grant_valid          arbiter has a winner
//   req_priority_vector  registered priority mask back to the arbiter
//   req_ready            one-hot beat accept toward the owning requester
//   out_valid            output beat valid
//   out_data             output beat data
//   out_idx              owning requester index
//   out_last             final beat of the burst
//   out_ready            downstream accept
//   busy                 burst in progress
// -----------------------------------------------------------------------------
module arb_burst_sequencer #(
    parameter int WIDTH  = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        req_vector,
    input  logic [WIDTH*DATA_W-1:0] req_data,
    input  logic [WIDTH*LEN_W-1:0]  req_len,
    input  logic [IDX_W-1:0]        grant_idx,
    input  logic                    grant_valid,
    output logic [WIDTH-1:0]        req_priority_vector,
    output logic [WIDTH-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [LEN_W-1:0]   count_reg, count_next;
    logic [WIDTH-1:0]   prio_reg,  prio_next;

    // The shift amount is one bit wider than the index.
    // When owner = WIDTH-1, owner + 1 must reach WIDTH and clear the whole
    // mask, rather than wrapping to a shift of 0.
    logic [IDX_W:0]     shamt;

    logic [DATA_W-1:0]  data_slice [WIDTH];
    logic [LEN_W-1:0]   len_slice  [WIDTH];
    logic               in_burst;
    logic               fire;

    assign in_burst = (state_reg == BURST);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_req
            assign data_slice[gi] = req_data[gi*DATA_W +: DATA_W];
            assign len_slice[gi]  = req_len[gi*LEN_W +: LEN_W];
            // Only the owner sees out_ready, and only while a burst is held.
            assign req_ready[gi]  = in_burst & out_ready & (owner_reg == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            owner_reg <= '0;
            count_reg <= '0;
            prio_reg  <= ALL_ONES;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            count_reg <= count_next;
            prio_reg  <= prio_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        count_next = count_reg;
        prio_next  = prio_reg;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        fire       = 1'b0;
        shamt      = {1'b0, owner_reg} + (IDX_W+1)'(1);

        unique case (state_reg)
            IDLE: begin
                // The winner and its length are captured here only. Later
                // grant or length changes cannot disturb the locked burst.
                if (grant_valid) begin
                    owner_next = grant_idx;
                    count_next = len_slice[grant_idx];
                    state_next = BURST;
                end
            end
            BURST: begin
                // If the owner drops its valid, the burst simply stalls.
                // The count and ownership are held, and nothing is aborted.
                out_valid = req_vector[owner_reg];
                out_last  = out_valid & (count_reg == '0);
                fire      = out_valid & out_ready;
                if (fire) begin
                    if (count_reg != '0) begin
                        count_next = count_reg - LEN_W'(1);
                    end else begin
                        prio_next  = ALL_ONES << shamt;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_priority_vector = prio_reg;
    assign out_data            = data_slice[owner_reg];
    assign out_idx             = owner_reg;
    assign busy                = in_burst;

endmodule

// File: tb/tb_arb_burst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_arb_burst_sequencer
//
// Self-checking bench for arb_burst_sequencer, run with WIDTH=4, DATA_W=8 and
// LEN_W=4.
//
// Each started burst pushes its expected beats onto a scoreboard queue. The
// beats are popped and compared whenever the DUT hands off a beat.
//
// A table of per-cycle vectors covers the basic single burst. Hand-written
// sequences cover backpressure, requester stall, priority wrap with grant
// lock, and asynchronous reset in the middle of a burst.
// -----------------------------------------------------------------------------
module tb_arb_burst_sequencer;

    localparam int W  = 4;
    localparam int DW = 8;
    localparam int LW = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [W-1:0]      req_vector;
    logic [W*DW-1:0]   req_data;
    logic [W*LW-1:0]   req_len;
    logic [IW-1:0]     grant_idx;
    logic              grant_valid;
    logic [W-1:0]      req_priority_vector;
    logic [W-1:0]      req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_idx;
    logic              out_last;
    logic              out_ready;
    logic              busy;

    always #5 clk = ~clk;

    arb_burst_sequencer #(
        .WIDTH  (W),
        .DATA_W (DW),
        .LEN_W  (LW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_vector          (req_vector),
        .req_data            (req_data),
        .req_len             (req_len),
        .grant_idx           (grant_idx),
        .grant_valid         (grant_valid),
        .req_priority_vector (req_priority_vector),
        .req_ready           (req_ready),
        .out_valid           (out_valid),
        .out_data            (out_data),
        .out_idx             (out_idx),
        .out_last            (out_last),
        .out_ready           (out_ready),
        .busy                (busy)
    );

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic          gv;
        logic [IW-1:0] gidx;
        logic          rdy;
        logic [W-1:0]  rv;
        logic          e_busy;
        logic          e_valid;
        logic          e_last;
        logic [IW-1:0] e_idx;
        logic [W-1:0]  e_rr;
        logic [W-1:0]  e_prio;
    } vec_t;

    beat_t        sb[$];
    vec_t         tbl[6];
    int           checks   = 0;
    int           failures = 0;
    logic [DW-1:0] base [W];
    int           beat_no [W];
    logic [W-1:0] accepted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Requester model: each requester presents base + beat count and moves to
    // its next beat only after its req_ready has been seen with valid high.
    task automatic drive_data();
        for (int i = 0; i < W; i++)
            req_data[i*DW +: DW] = base[i] + DW'(beat_no[i]);
    endtask

    task automatic start_req(input int i, input logic [DW-1:0] b, input int len);
        base[i]    = b;
        beat_no[i] = 0;
        req_len[i*LW +: LW] = LW'(len);
        for (int k = 0; k <= len; k++)
            sb.push_back('{idx: IW'(i), data: b + DW'(k), last: (k == len)});
        drive_data();
    endtask

    // Compare at the falling edge any beat that will fire at the next rising edge.
    task automatic sample();
        @(negedge clk);
        accepted = req_ready & req_vector;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_beat actual idx=%0d data=%0h required no beat", out_idx, out_data);
            end else begin
                beat_t e;
                e = sb.pop_front();
                $display("beat idx=%0d data=%0h last=%0b", out_idx, out_data, out_last);
                check("beat_idx",       32'(out_idx),   32'(e.idx));
                check("beat_data",      32'(out_data),  32'(e.data));
                check("beat_last",      32'(out_last),  32'(e.last));
                check("beat_req_ready", 32'(req_ready), 32'(1) << e.idx);
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        for (int i = 0; i < W; i++)
            if (accepted[i]) beat_no[i]++;
        drive_data();
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        // Cycle 0 idle, grant at cycle 1, beats in cycles 2..4, idle again in cycle 5.
        //            gv    gidx  rdy   rv        busy  val   last  idx   rr        prio
        tbl[0] = '{1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b1111};
        tbl[1] = '{1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b1111};
        tbl[2] = '{1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0100, 4'b1111};
        tbl[3] = '{1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0100, 4'b1111};
        tbl[4] = '{1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 4'b1111};
        tbl[5] = '{1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b1000};

        reset       = 1'b0;
        req_vector  = '0;
        req_data    = '0;
        req_len     = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        out_ready   = 1'b0;
        accepted    = '0;
        for (int i = 0; i < W; i++) begin
            base[i]    = '0;
            beat_no[i] = 0;
        end

        // Reset without any clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst_prio",      32'(req_priority_vector), 32'hF);
        check("rst_busy",      32'(busy),                32'h0);
        check("rst_out_valid", 32'(out_valid),           32'h0);
        check("rst_req_ready", 32'(req_ready),           32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single burst, table driven.
        start_req(2, 8'hA0, 2);
        for (int r = 0; r < 6; r++) begin
            grant_valid = tbl[r].gv;
            grant_idx   = tbl[r].gidx;
            out_ready   = tbl[r].rdy;
            req_vector  = tbl[r].rv;
            sample();
            $display("cycle %0d busy=%0b valid=%0b last=%0b idx=%0d rr=%b prio=%b",
                     r, busy, out_valid, out_last, out_idx, req_ready, req_priority_vector);
            check($sformatf("tbl%0d_busy", r),  32'(busy),      32'(tbl[r].e_busy));
            check($sformatf("tbl%0d_valid", r), 32'(out_valid), 32'(tbl[r].e_valid));
            check($sformatf("tbl%0d_last", r),  32'(out_last),  32'(tbl[r].e_last));
            check($sformatf("tbl%0d_rr", r),    32'(req_ready), 32'(tbl[r].e_rr));
            check($sformatf("tbl%0d_prio", r),  32'(req_priority_vector), 32'(tbl[r].e_prio));
            if (tbl[r].e_valid)
                check($sformatf("tbl%0d_idx", r), 32'(out_idx), 32'(tbl[r].e_idx));
            advance();
        end
        check("single_sb_empty", 32'(sb.size()), 32'h0);

        // Backpressure: out_ready low for 2 cycles after the first beat.
        start_req(2, 8'hB0, 2);
        req_vector = 4'b0100; grant_idx = 2'd2; grant_valid = 1'b1; out_ready = 1'b1;
        step();
        grant_valid = 1'b0;
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sample();
            check("bp_req_ready", 32'(req_ready), 32'h0);
            check("bp_out_valid", 32'(out_valid), 32'h1);
            check("bp_out_last",  32'(out_last),  32'h0);
            check("bp_out_data",  32'(out_data),  32'hB1);
            advance();
        end
        out_ready = 1'b1;
        step();
        step();
        req_vector = '0;
        sample();
        check("bp_busy_after", 32'(busy), 32'h0);
        check("bp_sb_empty",   32'(sb.size()), 32'h0);
        check("bp_prio",       32'(req_priority_vector), 32'h8);
        advance();

        // Requester stall: req_vector[2] low for 3 cycles mid-burst.
        start_req(2, 8'hC0, 2);
        req_vector = 4'b0100; grant_idx = 2'd2; grant_valid = 1'b1;
        step();
        grant_valid = 1'b0;
        step();
        req_vector = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("stall_out_valid", 32'(out_valid), 32'h0);
            check("stall_busy",      32'(busy),      32'h1);
            check("stall_last",      32'(out_last),  32'h0);
            advance();
        end
        req_vector = 4'b0100;
        step();
        step();
        req_vector = '0;
        sample();
        check("stall_busy_after", 32'(busy), 32'h0);
        check("stall_sb_empty",   32'(sb.size()), 32'h0);
        advance();

        // Wrap: requester 3 with len 0 clears the whole priority mask.
        start_req(3, 8'hD0, 0);
        req_vector = 4'b1000; grant_idx = 2'd3; grant_valid = 1'b1;
        step();
        grant_valid = 1'b0;
        step();
        req_vector = '0;
        sample();
        check("wrap_prio", 32'(req_priority_vector), 32'h0);
        check("wrap_busy", 32'(busy), 32'h0);
        advance();

        // Grant lock: grant_idx toggles every cycle during a len 3 burst.
        start_req(1, 8'hE0, 3);
        req_vector = 4'b0010; grant_idx = 2'd1; grant_valid = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            grant_idx   = (k % 2 == 0) ? 2'd3 : 2'd0;
            grant_valid = (k < 3);
            sample();
            check("lock_out_idx", 32'(out_idx), 32'h1);
            advance();
        end
        req_vector = '0;
        sample();
        check("lock_prio",     32'(req_priority_vector), 32'hC);
        check("lock_busy",     32'(busy), 32'h0);
        check("lock_sb_empty", 32'(sb.size()), 32'h0);
        advance();

        // Asynchronous reset at beat 2 of a 4-beat burst.
        start_req(0, 8'hF0, 3);
        req_vector = 4'b0001; grant_idx = 2'd0; grant_valid = 1'b1;
        step();
        grant_valid = 1'b0;
        step();
        check("ar_busy_before",  32'(busy),      32'h1);
        check("ar_valid_before", 32'(out_valid), 32'h1);
        #1 reset = 1'b1;
        #1;
        check("ar_busy",      32'(busy),                32'h0);
        check("ar_out_valid", 32'(out_valid),           32'h0);
        check("ar_req_ready", 32'(req_ready),           32'h0);
        check("ar_prio",      32'(req_priority_vector), 32'hF);
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        sample();
        check("ar_idle_busy",  32'(busy),      32'h0);
        check("ar_idle_valid", 32'(out_valid), 32'h0);
        advance();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
